// File: rtl/jam_search.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : jam_search
// Brief    : Exhaustive N-worker/N-job assignment search over all permutations
//            in lexicographic order; reports best total, tie count, first best.
// Revision : 1.0 - initial release
// ============================================================================
module jam_search #(
    parameter  int N      = 8,
    parameter  int COST_W = 7,
    parameter  int CNT_W  = 16,
    localparam int IW     = (N > 2) ? $clog2(N) : 1,
    localparam int SUM_W  = COST_W + $clog2(N)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                Start,
    input  logic                Mode,
    output logic [IW-1:0]       W,
    output logic [IW-1:0]       J,
    input  logic [COST_W-1:0]   Cost,
    output logic                Busy,
    output logic                Valid,
    output logic [SUM_W-1:0]    BestCost,
    output logic [CNT_W-1:0]    MatchCount,
    output logic [N*IW-1:0]     BestPerm
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EVAL  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic [N-1:0][IW-1:0]   r_perm;
    logic [N-1:0][IW-1:0]   r_best_perm;
    logic [IW-1:0]          r_idx;
    logic [SUM_W-1:0]       r_sum;
    logic [SUM_W-1:0]       r_best;
    logic [CNT_W-1:0]       r_count;
    logic                   r_mode;
    logic                   r_first;

    logic [N-1:0][IW-1:0]   w_perm_ident;
    logic [N-1:0][IW-1:0]   w_perm_swp;
    logic [N-1:0][IW-1:0]   w_perm_nxt;
    logic                   w_has_pivot;
    int                     w_piv;
    int                     w_succ;
    logic [IW-1:0]          w_piv_val;
    logic [IW-1:0]          w_succ_val;
    logic                   w_better;
    logic                   w_last_fetch;

    always_comb begin
        w_perm_ident = '0;
        for (int k = 0; k < N; k++) begin
            w_perm_ident[k] = IW'(k);
        end
    end

    // Next lexicographic permutation: pivot, swap with rightmost larger, reverse suffix.
    always_comb begin
        w_has_pivot = 1'b0;
        w_piv       = 0;
        for (int i = 0; i < N-1; i++) begin
            if (r_perm[i] < r_perm[i+1]) begin
                w_has_pivot = 1'b1;
                w_piv       = i;
            end
        end
        w_piv_val = '0;
        for (int k = 0; k < N; k++) begin
            if (k == w_piv) w_piv_val = r_perm[k];
        end
        w_succ     = 0;
        w_succ_val = '0;
        for (int k = 0; k < N; k++) begin
            if (k > w_piv && r_perm[k] > w_piv_val) begin
                w_succ     = k;
                w_succ_val = r_perm[k];
            end
        end
        w_perm_swp = r_perm;
        for (int k = 0; k < N; k++) begin
            if (k == w_piv)  w_perm_swp[k] = w_succ_val;
            if (k == w_succ) w_perm_swp[k] = w_piv_val;
        end
        w_perm_nxt = w_perm_swp;
        for (int k = 0; k < N; k++) begin
            for (int m = 0; m < N; m++) begin
                if (k > w_piv && m == N + w_piv - k) w_perm_nxt[k] = w_perm_swp[m];
            end
        end
    end

    assign w_better     = r_mode ? (r_sum > r_best) : (r_sum < r_best);
    assign w_last_fetch = (r_idx == IW'(N-1));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= S_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (Start) w_state_nxt = S_FETCH;
            S_FETCH: if (w_last_fetch) w_state_nxt = S_EVAL;
            S_EVAL:  w_state_nxt = w_has_pivot ? S_FETCH : S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_perm      <= '0;
            r_best_perm <= '0;
            r_idx       <= '0;
            r_sum       <= '0;
            r_best      <= '0;
            r_count     <= '0;
            r_mode      <= 1'b0;
            r_first     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_perm      <= w_perm_ident;
                        r_best_perm <= '0;
                        r_idx       <= '0;
                        r_sum       <= '0;
                        r_best      <= '0;
                        r_count     <= '0;
                        r_mode      <= Mode;
                        r_first     <= 1'b1;
                    end
                end
                S_FETCH: begin
                    r_sum <= r_sum + SUM_W'(Cost);
                    // idx parks on N-1 so W/J hold through EVAL
                    if (!w_last_fetch) r_idx <= r_idx + IW'(1);
                end
                S_EVAL: begin
                    if (r_first || w_better) begin
                        r_best      <= r_sum;
                        r_count     <= CNT_W'(1);
                        r_best_perm <= r_perm;
                        r_first     <= 1'b0;
                    end else if (r_sum == r_best) begin
                        if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
                    end
                    if (w_has_pivot) begin
                        r_perm <= w_perm_nxt;
                        r_sum  <= '0;
                        r_idx  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        J = '0;
        for (int k = 0; k < N; k++) begin
            if (r_idx == IW'(k)) J = r_perm[k];
        end
    end

    assign W          = r_idx;
    assign Busy       = (r_state == S_FETCH) || (r_state == S_EVAL);
    assign Valid      = (r_state == S_DONE);
    assign BestCost   = r_best;
    assign MatchCount = r_count;
    assign BestPerm   = r_best_perm;

endmodule
`default_nettype wire

// File: tb/tb_jam_search.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_jam_search
// Brief    : Directed, table-driven bench for jam_search (N=3 and N=4 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jam_search;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        mode;
    int          sel;
    int          n_checks;
    int          n_fail;

    // DUT A: N=3 product matrix; DUT B: N=3 flat costs, 2-bit count; DUT C: N=4 modular
    logic [1:0]  w_a, j_a, w_b, j_b, w_c, j_c;
    logic [6:0]  cost_a, cost_b, cost_c;
    logic        busy_a, busy_b, busy_c, valid_a, valid_b, valid_c;
    logic        start_a, start_b, start_c;
    logic [8:0]  best_a, best_b, best_c;
    logic [15:0] cnt_a, cnt_c;
    logic [1:0]  cnt_b;
    logic [5:0]  perm_a, perm_b;
    logic [7:0]  perm_c;

    logic [31:0] m_w, m_j, m_best, m_cnt, m_perm;
    logic        m_busy, m_valid;
    logic [31:0] hist_w [8];
    logic [31:0] hist_j [8];

    always #5 clk = ~clk;

    assign start_a = start && (sel == 0);
    assign start_b = start && (sel == 1);
    assign start_c = start && (sel == 2);

    assign cost_a = 7'((32'(w_a) + 1) * (32'(j_a) + 1));
    assign cost_b = 7'd5;
    assign cost_c = 7'((32'(w_c) + 32'(j_c)) % 4);

    jam_search #(.N(3), .COST_W(7), .CNT_W(16)) u_a (
        .CLK(clk), .RST(rst_n), .Start(start_a), .Mode(mode), .W(w_a), .J(j_a),
        .Cost(cost_a), .Busy(busy_a), .Valid(valid_a), .BestCost(best_a),
        .MatchCount(cnt_a), .BestPerm(perm_a));

    jam_search #(.N(3), .COST_W(7), .CNT_W(2)) u_b (
        .CLK(clk), .RST(rst_n), .Start(start_b), .Mode(mode), .W(w_b), .J(j_b),
        .Cost(cost_b), .Busy(busy_b), .Valid(valid_b), .BestCost(best_b),
        .MatchCount(cnt_b), .BestPerm(perm_b));

    jam_search #(.N(4), .COST_W(7), .CNT_W(16)) u_c (
        .CLK(clk), .RST(rst_n), .Start(start_c), .Mode(mode), .W(w_c), .J(j_c),
        .Cost(cost_c), .Busy(busy_c), .Valid(valid_c), .BestCost(best_c),
        .MatchCount(cnt_c), .BestPerm(perm_c));

    always_comb begin
        m_w = 32'(w_a); m_j = 32'(j_a); m_busy = busy_a; m_valid = valid_a;
        m_best = 32'(best_a); m_cnt = 32'(cnt_a); m_perm = 32'(perm_a);
        if (sel == 1) begin
            m_w = 32'(w_b); m_j = 32'(j_b); m_busy = busy_b; m_valid = valid_b;
            m_best = 32'(best_b); m_cnt = 32'(cnt_b); m_perm = 32'(perm_b);
        end else if (sel == 2) begin
            m_w = 32'(w_c); m_j = 32'(j_c); m_busy = busy_c; m_valid = valid_c;
            m_best = 32'(best_c); m_cnt = 32'(cnt_c); m_perm = 32'(perm_c);
        end
    end

    typedef struct {
        int    dut;
        logic  mode;
        int    best;
        int    count;
        int    perm;
        int    lat;
        string name;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_start(input logic md);
        @(negedge clk);
        start = 1'b1;
        mode  = md;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns the number of edges after the Start edge at which Valid was seen.
    task automatic wait_done(input string name, output int lat);
        lat = 0;
        while (!m_valid && lat < 200) begin
            if (lat < 8) begin
                hist_w[lat] = m_w;
                hist_j[lat] = m_j;
            end
            @(negedge clk);
            lat++;
        end
        check({name, "_done"}, 32'(m_valid), 32'd1);
    endtask

    task automatic check_results(input vec_t v, input string name);
        check({name, "_best"},  m_best, 32'(v.best));
        check({name, "_count"}, m_cnt,  32'(v.count));
        check({name, "_perm"},  m_perm, 32'(v.perm));
    endtask

    task automatic run_and_check(input vec_t v);
        int lat;
        sel = v.dut;
        pulse_start(v.mode);
        check({v.name, "_busy"}, 32'(m_busy), 32'd1);
        wait_done(v.name, lat);
        check({v.name, "_latency"}, 32'(lat), 32'(v.lat));
        check_results(v, v.name);
        @(negedge clk);
        check({v.name, "_pulse"}, 32'(m_valid), 32'd0);
        check({v.name, "_idle"},  32'(m_busy),  32'd0);
    endtask

    initial begin
        int lat;
        logic busy_ok;
        logic [31:0] exp_w [7];
        logic [31:0] exp_j [7];

        vecs[0] = '{0, 1'b0, 10, 1, 6'b000110, 24,  "a_min"};
        vecs[1] = '{0, 1'b1, 14, 1, 6'b100100, 24,  "a_max"};
        vecs[2] = '{1, 1'b0, 15, 3, 6'b100100, 24,  "b_tie"};
        vecs[3] = '{2, 1'b0, 0,  1, 8'h6C,     120, "c_min"};
        vecs[4] = '{2, 1'b1, 12, 1, 8'h1B,     120, "c_max"};
        exp_w = '{0, 1, 2, 2, 0, 1, 2};
        exp_j = '{0, 1, 2, 2, 0, 2, 1};

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        mode     = 1'b0;
        sel      = 0;

        repeat (2) @(negedge clk);
        check("rst_w",     m_w,             32'd0);
        check("rst_j",     m_j,             32'd0);
        check("rst_busy",  32'(m_busy),     32'd0);
        check("rst_valid", 32'(m_valid),    32'd0);
        check("rst_best",  m_best,          32'd0);
        check("rst_count", m_cnt,           32'd0);
        check("rst_perm",  m_perm,          32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            run_and_check(vecs[i]);
        end

        // Lookup order of the first two permutations
        run_and_check(vecs[0]);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("wj_seq_w%0d", i), hist_w[i], exp_w[i]);
            check($sformatf("wj_seq_j%0d", i), hist_j[i], exp_j[i]);
        end

        // Start held high for the whole run
        sel = 0;
        @(negedge clk);
        start = 1'b1;
        mode  = 1'b0;
        @(negedge clk);
        busy_ok = 1'b1;
        lat = 0;
        while (!m_valid && lat < 200) begin
            if (!m_busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("held_busy",    32'(busy_ok), 32'd1);
        check("held_latency", 32'(lat),     32'd24);
        check_results(vecs[0], "held");
        @(negedge clk);
        check("held_no_restart", 32'(m_busy), 32'd0);

        // Start in the Valid cycle is ignored
        pulse_start(1'b0);
        wait_done("vcyc", lat);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("vcyc_ignored_a", 32'(m_busy), 32'd0);
        @(negedge clk);
        check("vcyc_ignored_b", 32'(m_busy), 32'd0);

        // Start in the cycle right after Valid is accepted
        pulse_start(1'b1);
        wait_done("pre", lat);
        pulse_start(1'b0);
        check("next_start_busy", 32'(m_busy), 32'd1);
        wait_done("next", lat);
        check("next_latency", 32'(lat), 32'd24);
        check_results(vecs[0], "next");
        @(negedge clk);

        // Asynchronous reset mid-FETCH, then a clean rerun
        pulse_start(1'b0);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_w",     m_w,          32'd0);
        check("arst_j",     m_j,          32'd0);
        check("arst_busy",  32'(m_busy),  32'd0);
        check("arst_valid", 32'(m_valid), 32'd0);
        check("arst_best",  m_best,       32'd0);
        check("arst_count", m_cnt,        32'd0);
        check("arst_perm",  m_perm,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_and_check(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/jam_search.md
# jam_search

Parametrised exhaustive job-assignment search engine, the generalised successor of the fixed 8×8 JAM block. On a `Start` request it walks every permutation of N workers to N jobs in lexicographic order. For each permutation it reads each worker/job cost from the external cost table through the `W`/`J`/`Cost` lookup port and accumulates the total. It reports the best total (minimum or maximum, selectable per run), how many permutations reach that total, and the first permutation that reached it. It sits between the cost-table memory/bench and the result consumer.

## Interface
- N, 8, worker/job count; legal range 2..8.
- COST_W, 7, width of one cost entry.
- CNT_W, 16, width of MatchCount; the count saturates at 2^CNT_W−1.
- Derived widths (localparams):
  - IW = max(1, clog2(N)).
  - SUM_W = COST_W + clog2(N); 10 at the defaults.
- CLK  in  1  sole clock; all state changes on its rising edge.
- RST  in  1  reset; asynchronous, active-low.
- Start  in  1  run request; sampled only in IDLE.
- Mode  in  1  0 = minimise, 1 = maximise; sampled together with Start.
- W  out  IW  worker index of the current lookup.
- J  out  IW  job index of the current lookup.
- Cost  in  COST_W  cost(W,J); must be valid in the same cycle W/J are driven, and is sampled at the next rising edge.
- Busy  out  1  high from the cycle after Start is accepted until Valid.
- Valid  out  1  one-cycle pulse; results are final.
- BestCost  out  SUM_W  best total found.
- MatchCount  out  CNT_W  number of permutations whose total equals BestCost.
- BestPerm  out  N*IW  job assigned to worker i, in bits [i*IW +: IW].

## Operation
- State machine: IDLE → FETCH → EVAL → (FETCH | DONE) → IDLE.
- IDLE
  - When Start=1: perm ← identity (0,1,…,N−1), idx ← 0, sum ← 0, Mode latched, best/count/BestPerm cleared, first ← 1. Go to FETCH.
  - Start while Busy is ignored.
- FETCH (N cycles)
  - Drives W = idx and J = perm[idx].
  - Each cycle: sum ← sum + Cost, idx ← idx + 1.
  - After the cycle with idx = N−1, go to EVAL.
- EVAL (1 cycle); W/J hold their last values.
  - If first: best ← sum, count ← 1, BestPerm ← perm, first ← 0.
  - Else if sum is strictly better (< when minimising, > when maximising): best ← sum, count ← 1, BestPerm ← perm.
  - Else if sum = best: count ← count + 1, saturating at 2^CNT_W−1. BestPerm is kept, so it is always the lexicographically smallest optimal permutation.
  - If perm is the last permutation (strictly descending): go to DONE.
  - Otherwise, in the same cycle, apply the combinational next-permutation:
    - pivot = rightmost i with perm[i] < perm[i+1];
    - swap perm[i] with the rightmost larger element of the suffix;
    - reverse the suffix.
  - Then sum ← 0, idx ← 0, go to FETCH.
- DONE (1 cycle): Valid=1, Busy=0, go to IDLE.
- BestCost, MatchCount and BestPerm hold until the next accepted Start.
- Arithmetic: sum and best are unsigned SUM_W; no overflow is possible at legal parameters.
- Reset (asynchronous, including mid-run):
  - state IDLE;
  - W, J, Busy, Valid, BestCost, MatchCount, BestPerm all 0;
  - partial results are discarded.

## Timing
- Edge E0 samples Start=1; Busy=1 and the FETCH of permutation 0 begin in the cycle after E0.
- Each permutation takes exactly N+1 cycles (N FETCH + 1 EVAL), with no bubbles.
- Valid rises at edge E0 + N!·(N+1) and is high for exactly one cycle; Busy falls at that same edge.
  - N=3: 24 cycles.
  - N=8: 362880 cycles.
- Start may be asserted in the cycle Valid is high. It is not accepted there: acceptance happens in IDLE, so the earliest restart is sampled at the edge after DONE.
- The Cost lookup has zero latency: the bench/memory drives Cost combinationally from W/J within the cycle.

## Test plan
- Minimise, N=3, COST_W=7, cost rows {1,2,3}, {2,4,6}, {3,6,9}; Start pulsed, Mode=0 → Valid exactly 24 cycles after the Start edge, BestCost=10, MatchCount=1, BestPerm=6'b000110 (jobs 2,1,0). Verify the W/J sequence starts (0,0),(1,1),(2,2) and then (0,0),(1,2),(2,1).
- Same matrix with Mode=1 → BestCost=14, MatchCount=1, BestPerm=6'b100100 (identity).
- Tie and saturation: N=3, CNT_W=2, all costs 5 → BestCost=15, MatchCount=3 (6 ties saturated), BestPerm = identity.
- Default N=8, cost(w,j)=(w+j) mod 8 → BestCost=0, MatchCount=1, BestPerm gives job (8−w) mod 8 for w≥1 and 0 for w=0. Valid 362880 cycles after Start.
- Start held high during a run → no restart, Busy stays 1, and results match a single run. Start in the Valid cycle → ignored; Start on the following cycle → a new run begins.
- RST driven low mid-FETCH, asynchronously between edges → all outputs 0 immediately. After release plus a Start, the full run repeats and gives the same results as an undisturbed run.
